// File: rtl/quad_spi_tx.sv
// rtl/quad_spi_tx.sv - multi-lane SPI-style serializer with input FIFO
module quad_spi_tx #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int DIV        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in,
    output logic [LANES-1:0]                  out,
    output logic                              clk_out,
    output logic                              en_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int BEATS = DATA_W / LANES;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam int DCW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic [LW-1:0]     count_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_next;
    logic [DCW-1:0]    div_cnt;
    logic [DCW-1:0]    div_cnt_next;
    logic              phase;
    logic              phase_next;
    logic [BW-1:0]     beat_cnt;
    logic [BW-1:0]     beat_cnt_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [LANES-1:0]  beat_data;
    logic              div_last;
    logic              beat_end;
    logic              word_end;

    assign full       = (count == LW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign fifo_level = count;

    // The lane slice being presented always sits at the leading edge of the
    // shift register; the register is shifted once per completed beat.
    assign beat_data = (MSB_FIRST != 0) ? shreg[DATA_W-1 -: LANES] : shreg[LANES-1:0];

    assign div_last = (div_cnt == DCW'(DIV - 1));
    assign beat_end = div_last && phase;
    assign word_end = beat_end && (beat_cnt == BW'(BEATS - 1));

    // FIFO storage write; contents need no reset because pointers/count flush it
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    // Occupancy after this cycle's push/pop, used for the count and busy
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + LW'(1);
            2'b01:   count_next = count - LW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // FSM and beat-timing counters register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            phase    <= 1'b0;
            beat_cnt <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            phase    <= phase_next;
            beat_cnt <= beat_cnt_next;
            shreg    <= shreg_next;
        end
    end

    // Next-state: load a word from the FIFO, step div/phase/beat counters,
    // chain straight into the next word at the end of a frame if one waits
    always_comb begin
        state_next    = state;
        div_cnt_next  = div_cnt;
        phase_next    = phase;
        beat_cnt_next = beat_cnt;
        shreg_next    = shreg;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    shreg_next    = mem[rd_ptr];
                    div_cnt_next  = '0;
                    phase_next    = 1'b0;
                    beat_cnt_next = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (word_end) begin
                    div_cnt_next  = '0;
                    phase_next    = 1'b0;
                    beat_cnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shreg_next = mem[rd_ptr];
                    end else begin
                        state_next = IDLE;
                    end
                end else if (beat_end) begin
                    div_cnt_next  = '0;
                    phase_next    = 1'b0;
                    beat_cnt_next = beat_cnt + BW'(1);
                    shreg_next    = (MSB_FIRST != 0) ? (shreg << LANES) : (shreg >> LANES);
                end else if (div_last) begin
                    div_cnt_next = '0;
                    phase_next   = 1'b1;
                end else begin
                    div_cnt_next = div_cnt + DCW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered pin outputs: one cycle behind the FSM so a pop at edge N+1
    // shows its first beat after edge N+2; busy mirrors state/level after the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            clk_out <= 1'b0;
            en_out  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_next != IDLE) || (count_next != '0);
            if (state == SHIFT) begin
                en_out  <= 1'b1;
                clk_out <= phase;
                out     <= beat_data;
            end else begin
                en_out  <= 1'b0;
                clk_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_spi_tx.sv
// tb/tb_quad_spi_tx.sv - self-checking bench for quad_spi_tx
module tb_quad_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: defaults (8 bit, 4 lanes, DIV 2, depth 4, MSB first)
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] a_in = 8'h00;
    logic [3:0] a_out;
    logic       a_clk_out, a_en, a_busy;
    logic [2:0] a_level;

    // instance B: 16 bit, 2 lanes, LSB first
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_in = 16'h0000;
    logic [1:0]  b_out;
    logic        b_clk_out, b_en, b_busy;
    logic [2:0]  b_level;

    // instance C: DIV = 1
    logic       c_valid = 1'b0;
    logic       c_ready;
    logic [7:0] c_in = 8'h00;
    logic [3:0] c_out;
    logic       c_clk_out, c_en, c_busy;
    logic [2:0] c_level;

    quad_spi_tx u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in(a_in),
        .out(a_out), .clk_out(a_clk_out), .en_out(a_en), .busy(a_busy), .fifo_level(a_level)
    );

    quad_spi_tx #(.DATA_W(16), .LANES(2), .DIV(2), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in(b_in),
        .out(b_out), .clk_out(b_clk_out), .en_out(b_en), .busy(b_busy), .fifo_level(b_level)
    );

    quad_spi_tx #(.DATA_W(8), .LANES(4), .DIV(1), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in(c_in),
        .out(c_out), .clk_out(c_clk_out), .en_out(c_en), .busy(c_busy), .fifo_level(c_level)
    );

    int checks = 0;
    int errors = 0;

    int cap_a[$], cap_b[$], cap_c[$];
    int runs_a[$], runs_b[$], runs_c[$];
    int run_a = 0, run_b = 0, run_c = 0;
    int full_seen = 0, full_bad = 0;
    int exp_q[$];
    logic [7:0] words_a[$];

    typedef struct {
        logic [7:0] word;
        logic [3:0] hi;
        logic [3:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples are encoded clk_out*256 + out, one per en_out-high cycle.
    initial forever begin
        @(negedge clk);
        if (a_en === 1'b1) begin
            cap_a.push_back(int'(a_clk_out) * 256 + int'(a_out));
            run_a++;
        end else if (run_a > 0) begin
            runs_a.push_back(run_a);
            run_a = 0;
        end
        if (b_en === 1'b1) begin
            cap_b.push_back(int'(b_clk_out) * 256 + int'(b_out));
            run_b++;
        end else if (run_b > 0) begin
            runs_b.push_back(run_b);
            run_b = 0;
        end
        if (c_en === 1'b1) begin
            cap_c.push_back(int'(c_clk_out) * 256 + int'(c_out));
            run_c++;
        end else if (run_c > 0) begin
            runs_c.push_back(run_c);
            run_c = 0;
        end
        if (a_level == 3'd4) begin
            full_seen++;
            if (a_ready !== 1'b0) full_bad++;
        end
        if (a_level > 3'd4) full_bad++;
    end

    // Reference: a word is BEATS lane slices, each held for 2*DIV cycles,
    // clk_out low for the first DIV of them and high for the rest.
    task automatic model_frame(input int dw, input int lanes, input int div, input int msb,
                               input logic [63:0] word);
        int beats;
        beats = dw / lanes;
        for (int b = 0; b < beats; b++) begin
            int sh;
            int v;
            logic [63:0] mask;
            sh   = (msb != 0) ? (dw - lanes * (b + 1)) : (lanes * b);
            mask = (64'd1 << lanes) - 64'd1;
            v    = int'(32'((word >> sh) & mask));
            for (int k = 0; k < 2 * div; k++) begin
                exp_q.push_back(((k >= div) ? 256 : 0) + v);
            end
        end
    endtask

    task automatic check_stream(input string name, input int cap[$]);
        int n;
        check({name, " length"}, cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", name, i), cap[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic send_a(input logic [7:0] w, input int gap);
        int guard;
        guard = 0;
        @(negedge clk);
        if (gap > 0) begin
            a_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        a_in    = w;
        a_valid = 1'b1;
        while (a_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            check("send_a ready timeout", guard, 0);
        end else begin
            @(posedge clk);
            words_a.push_back(w);
        end
    endtask

    task automatic release_a();
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((a_busy | a_en | b_busy | b_en | c_busy | c_en) !== 1'b0 && g < 3000);
        if (g >= 3000) check("idle timeout", g, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_a_stream(input string name);
        foreach (words_a[i]) model_frame(8, 4, 2, 1, 64'(words_a[i]));
        check_stream(name, cap_a);
        words_a.delete();
        cap_a.delete();
        runs_a.delete();
    endtask

    initial begin
        vec_t tbl [5];
        int   beats_b [8];
        int   sz;
        int   g;
        logic [15:0] rb;

        tbl[0] = '{8'hA5, 4'hA, 4'h5};
        tbl[1] = '{8'h00, 4'h0, 4'h0};
        tbl[2] = '{8'hFF, 4'hF, 4'hF};
        tbl[3] = '{8'h3C, 4'h3, 4'hC};
        tbl[4] = '{8'h81, 4'h8, 4'h1};
        beats_b = '{0, 1, 3, 0, 2, 0, 1, 0};

        // reset state, with a write attempted while reset is held
        a_in    = 8'h77;
        a_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst out", 32'(a_out), 0);
        check("rst clk_out", 32'(a_clk_out), 0);
        check("rst en_out", 32'(a_en), 0);
        check("rst busy", 32'(a_busy), 0);
        check("rst fifo_level", 32'(a_level), 0);
        check("rst in_ready", 32'(a_ready), 1);
        a_valid = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);
        check("post-rst level", 32'(a_level), 0);

        // single-word table: latency, beat values, clk_out pattern, frame length
        for (int t = 0; t < 5; t++) begin
            send_a(tbl[t].word, 0);
            @(negedge clk);
            a_valid = 1'b0;
            check($sformatf("lat%0d level N", t), 32'(a_level), 1);
            check($sformatf("lat%0d en N", t), 32'(a_en), 0);
            @(negedge clk);
            check($sformatf("lat%0d en N+1", t), 32'(a_en), 0);
            @(negedge clk);
            check($sformatf("lat%0d en N+2", t), 32'(a_en), 1);
            check($sformatf("lat%0d out N+2", t), 32'(a_out), 32'(tbl[t].hi));
            wait_quiet();
            check($sformatf("vec%0d frame len", t), cap_a.size(), 8);
            check($sformatf("vec%0d runs", t), runs_a.size(), 1);
            if (cap_a.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("vec%0d s%0d", t, k), cap_a[k],
                          (((k % 4) >= 2) ? 256 : 0) + int'((k < 4) ? tbl[t].hi : tbl[t].lo));
                end
            end
            check($sformatf("vec%0d en after", t), 32'(a_en), 0);
            check($sformatf("vec%0d busy after", t), 32'(a_busy), 0);
            words_a.delete();
            cap_a.delete();
            runs_a.delete();
        end

        // back-to-back burst: one contiguous 32-cycle frame
        for (int i = 0; i < 4; i++) send_a(8'(i), 0);
        release_a();
        wait_quiet();
        check("burst runs", runs_a.size(), 1);
        if (runs_a.size() > 0) check("burst run len", runs_a[0], 32);
        finish_a_stream("burst");

        // valid held for 6 words: FIFO fills, in_ready drops, nothing lost
        full_seen = 0;
        full_bad  = 0;
        for (int i = 0; i < 6; i++) send_a(8'(8'hC0 + i), 0);
        release_a();
        wait_quiet();
        check("full seen", 32'(full_seen > 0), 1);
        check("ready while full", full_bad, 0);
        check("held runs", runs_a.size(), 1);
        finish_a_stream("held6");

        // random traffic with random gaps
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(5, 12);
            for (int i = 0; i < n; i++) begin
                send_a(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0);
            end
            release_a();
            wait_quiet();
            foreach (runs_a[i]) check($sformatf("rnd%0d run%0d mod", r, i), runs_a[i] % 8, 0);
            finish_a_stream($sformatf("rnd%0d", r));
        end

        // reset mid-burst
        for (int i = 0; i < 4; i++) send_a(8'hE1 + 8'(i), 0);
        release_a();
        g = 0;
        while (cap_a.size() < 12 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("mid-rst reached burst", 32'(g < 200), 1);
        #2 rst = 1'b1;
        #1;
        check("mid-rst out", 32'(a_out), 0);
        check("mid-rst clk_out", 32'(a_clk_out), 0);
        check("mid-rst en_out", 32'(a_en), 0);
        check("mid-rst level", 32'(a_level), 0);
        check("mid-rst in_ready", 32'(a_ready), 1);
        check("mid-rst busy", 32'(a_busy), 0);
        a_in    = 8'h55;
        a_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("write during rst", 32'(a_level), 0);
        a_valid = 1'b0;
        rst     = 1'b0;
        sz = cap_a.size();
        repeat (40) @(negedge clk);
        check("no output after rst", cap_a.size(), sz);
        check("en after rst", 32'(a_en), 0);
        check("busy after rst", 32'(a_busy), 0);
        words_a.delete();
        cap_a.delete();
        runs_a.delete();

        // 16-bit, 2 lanes, LSB first
        @(negedge clk);
        b_in    = 16'h1234;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        wait_quiet();
        check("B runs", runs_b.size(), 1);
        if (runs_b.size() > 0) check("B run len", runs_b[0], 32);
        if (cap_b.size() >= 32) begin
            for (int i = 0; i < 8; i++) check($sformatf("B beat%0d", i), cap_b[4 * i] % 256, beats_b[i]);
        end
        model_frame(16, 2, 2, 0, 64'h1234);
        check_stream("B 1234", cap_b);
        cap_b.delete();
        runs_b.delete();
        rb = 16'($urandom);
        @(negedge clk);
        b_in    = rb;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        wait_quiet();
        model_frame(16, 2, 2, 0, 64'(rb));
        check_stream("B rnd", cap_b);
        cap_b.delete();
        runs_b.delete();

        // DIV = 1
        @(negedge clk);
        c_in    = 8'h3C;
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        wait_quiet();
        check("C runs", runs_c.size(), 1);
        if (runs_c.size() > 0) check("C run len", runs_c[0], 4);
        model_frame(8, 4, 1, 1, 64'h3C);
        check_stream("C 3C", cap_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
